// File: rtl/ws2811_strip_ctrl.sv
// Frame sequencer for a WS2811 LED strip.
// Walks the frame buffer one pixel at a time, hands each 24-bit word to an
// external bit serializer, then holds the line low for the latch period.
//
// Handshake (send / word_sent): send is the request and stays high, with
// rgb_data held stable, from the cycle after LOAD until word_sent is sampled
// high on a rising edge; send drops in the following cycle. word_sent is only
// meaningful while send is high and is ignored in every other state.
module ws2811_strip_ctrl #(
    parameter int NUM_LEDS     = 50,
    parameter int ADDR_WIDTH   = 8,
    parameter int RESET_CYCLES = 2600
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  continuous,
    output logic [ADDR_WIDTH-1:0] pixel_addr,
    output logic                  pixel_rd,
    input  logic [23:0]           pixel_data,
    output logic [23:0]           rgb_data,
    output logic                  send,
    input  logic                  word_sent,
    output logic                  busy,
    output logic                  frame_done,
    output logic [2:0]            fsm_state
);

    // Counter holds 0..RESET_CYCLES-1, sized with one spare code so the
    // terminal value is always representable.
    localparam int CNT_W = $clog2(RESET_CYCLES + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_LEDS - 1);
    localparam logic [CNT_W-1:0]      LAST_CNT = CNT_W'(RESET_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        SEND  = 3'd3,
        LATCH = 3'd4
    } state_t;

    state_t                state;
    state_t                next_state;
    logic [ADDR_WIDTH-1:0] index;
    logic [CNT_W-1:0]      latch_cnt;
    logic                  last_pixel;
    logic                  latch_end;

    // The index only changes on edges that enter FETCH, so driving the
    // address straight from it also holds the last value everywhere else.
    assign pixel_addr = index;
    assign fsm_state  = state;
    assign last_pixel = (index >= LAST_IDX);
    assign latch_end  = (latch_cnt >= LAST_CNT);

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and Moore outputs.
    always_comb begin
        next_state = state;
        pixel_rd   = 1'b0;
        send       = 1'b0;
        busy       = 1'b1;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) next_state = FETCH;
            end
            FETCH: begin
                pixel_rd   = 1'b1;
                next_state = LOAD;
            end
            LOAD: begin
                next_state = SEND;
            end
            SEND: begin
                send = 1'b1;
                if (word_sent) next_state = last_pixel ? LATCH : FETCH;
            end
            LATCH: begin
                frame_done = latch_end;
                if (latch_end) next_state = continuous ? FETCH : IDLE;
            end
            default: begin
                busy       = 1'b0;
                next_state = IDLE;
            end
        endcase
    end

    // Pixel index, latch timer and the word held for the serializer.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            index     <= '0;
            latch_cnt <= '0;
            rgb_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) index <= '0;
                end
                LOAD: begin
                    rgb_data <= pixel_data;
                end
                SEND: begin
                    if (word_sent) begin
                        if (last_pixel) latch_cnt <= '0;
                        else            index     <= index + 1'b1;
                    end
                end
                LATCH: begin
                    if (latch_end) begin
                        if (continuous) index <= '0;
                    end else begin
                        latch_cnt <= latch_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ws2811_strip_ctrl.sv
// Bench for ws2811_strip_ctrl: a 3-pixel strip and a 1-pixel strip, both
// with a 10-cycle latch, a registered frame buffer and a serializer model
// that acknowledges each word 5 cycles after send rises.
module tb_ws2811_strip_ctrl;

    localparam int N  = 3;
    localparam int AW = 8;
    localparam int RC = 10;
    localparam logic [1:0] K_READ = 2'd0;
    localparam logic [1:0] K_WORD = 2'd1;
    localparam logic [1:0] K_DONE = 2'd2;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- DUT A (3 pixels) ----------------
    logic          start = 1'b0;
    logic          continuous = 1'b0;
    logic [AW-1:0] pixel_addr;
    logic          pixel_rd;
    logic [23:0]   pixel_data = '0;
    logic [23:0]   rgb_data;
    logic          send;
    logic          word_sent;
    logic          busy;
    logic          frame_done;
    logic [2:0]    fsm_state;

    ws2811_strip_ctrl #(.NUM_LEDS(N), .ADDR_WIDTH(AW), .RESET_CYCLES(RC)) dut (
        .clock(clock), .reset(reset), .start(start), .continuous(continuous),
        .pixel_addr(pixel_addr), .pixel_rd(pixel_rd), .pixel_data(pixel_data),
        .rgb_data(rgb_data), .send(send), .word_sent(word_sent), .busy(busy),
        .frame_done(frame_done), .fsm_state(fsm_state)
    );

    // ---------------- DUT B (1 pixel) ----------------
    logic          start_b = 1'b0;
    logic          continuous_b = 1'b0;
    logic [AW-1:0] pixel_addr_b;
    logic          pixel_rd_b;
    logic [23:0]   pixel_data_b = '0;
    logic [23:0]   rgb_data_b;
    logic          send_b;
    logic          word_sent_b;
    logic          busy_b;
    logic          frame_done_b;
    logic [2:0]    fsm_state_b;

    ws2811_strip_ctrl #(.NUM_LEDS(1), .ADDR_WIDTH(AW), .RESET_CYCLES(RC)) dut_b (
        .clock(clock), .reset(reset), .start(start_b), .continuous(continuous_b),
        .pixel_addr(pixel_addr_b), .pixel_rd(pixel_rd_b), .pixel_data(pixel_data_b),
        .rgb_data(rgb_data_b), .send(send_b), .word_sent(word_sent_b), .busy(busy_b),
        .frame_done(frame_done_b), .fsm_state(fsm_state_b)
    );

    // ---------------- frame buffers (one-cycle read latency) ----------------
    logic [23:0] mem [N];
    always @(posedge clock) begin
        if (pixel_rd)   pixel_data   <= (pixel_addr < N) ? mem[pixel_addr] : 24'hDEAD00;
        if (pixel_rd_b) pixel_data_b <= (pixel_addr_b == 0) ? 24'h81AB01 : 24'hDEAD00;
    end

    // ---------------- serializer model + spurious acks ----------------
    logic ws_ser = 1'b0, ws_spur = 1'b0, ws_ser_b = 1'b0;
    bit   spur_en = 1'b0;
    int   ser_cnt = -1, ser_cnt_b = -1;
    bit   ser_prev = 1'b0, ser_prev_b = 1'b0;
    assign word_sent   = ws_ser | ws_spur;
    assign word_sent_b = ws_ser_b;

    initial forever begin
        @(posedge clock); #1;
        ws_ser   = 1'b0;
        ws_ser_b = 1'b0;
        if (reset) begin
            ser_cnt   = -1;
            ser_cnt_b = -1;
        end else begin
            if (send && !ser_prev) ser_cnt = 0;
            else if (ser_cnt >= 0) ser_cnt++;
            if (ser_cnt == 5) begin ws_ser = 1'b1; ser_cnt = -1; end
            if (send_b && !ser_prev_b) ser_cnt_b = 0;
            else if (ser_cnt_b >= 0)   ser_cnt_b++;
            if (ser_cnt_b == 5) begin ws_ser_b = 1'b1; ser_cnt_b = -1; end
        end
        ser_prev   = send;
        ser_prev_b = send_b;
        ws_spur    = spur_en && !send && !reset && ($urandom_range(0, 2) == 0);
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [25:0] exp_q[$];
    logic [25:0] exp_b_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic sb_pop(input string name, input bit use_b, input logic [25:0] act);
        logic [25:0] e;
        checks++;
        if ((use_b ? exp_b_q.size() : exp_q.size()) == 0) begin
            errors++;
            $display("FAIL %s: got event %h with nothing expected (t=%0t)", name, act, $time);
        end else begin
            e = use_b ? exp_b_q.pop_front() : exp_q.pop_front();
            if (act !== e) begin
                errors++;
                $display("FAIL %s: got %h expected %h (t=%0t)", name, act, e, $time);
            end
        end
    endtask

    // ---------------- monitor ----------------
    int fd_count = 0, fd_count_b = 0;
    bit send_prev_m = 0, have_ws = 0, after_fd = 0, cont_at_fd = 0;
    bit send_prev_b = 0, have_ws_b = 0, after_fd_b = 0;
    int last_ws_edge = 0, last_ws_edge_b = 0;
    logic [23:0] held_word = '0;

    initial forever begin
        @(negedge clock);
        if (reset) begin
            send_prev_m = 0; have_ws = 0; after_fd = 0;
            send_prev_b = 0; have_ws_b = 0; after_fd_b = 0;
        end else begin
            // ---- A ----
            if (after_fd) begin
                after_fd = 0;
                check("busy_after_done", 32'(busy), 32'(cont_at_fd));
                check("fetch_after_done", 32'(pixel_rd), 32'(cont_at_fd));
            end
            if (pixel_rd) sb_pop("read_addr", 1'b0, {K_READ, 24'(pixel_addr)});
            if (send && !send_prev_m) begin
                sb_pop("word", 1'b0, {K_WORD, rgb_data});
                held_word = rgb_data;
                if (have_ws) check("word_latency", 32'(cyc - last_ws_edge), 32'd2);
            end else if (send) begin
                check("word_stable", 32'(rgb_data), 32'(held_word));
            end
            // word_sent seen here is sampled by the DUT on the next rising edge
            if (send && word_sent) begin
                have_ws = 1;
                last_ws_edge = cyc + 1;
            end
            if (frame_done) begin
                sb_pop("frame_done", 1'b0, {K_DONE, 24'h0});
                check("latch_len", 32'(cyc - last_ws_edge + 1), 32'(RC));
                have_ws = 0;
                after_fd = 1;
                cont_at_fd = continuous;
                fd_count++;
            end
            send_prev_m = send;
            // ---- B ----
            if (after_fd_b) begin
                after_fd_b = 0;
                check("b_busy_after_done", 32'(busy_b), 32'd0);
            end
            if (busy_b) check("b_addr_zero", 32'(pixel_addr_b), 32'd0);
            if (pixel_rd_b) sb_pop("b_read_addr", 1'b1, {K_READ, 24'(pixel_addr_b)});
            if (send_b && !send_prev_b) sb_pop("b_word", 1'b1, {K_WORD, rgb_data_b});
            if (send_b && word_sent_b) begin
                have_ws_b = 1;
                last_ws_edge_b = cyc + 1;
            end
            if (frame_done_b) begin
                sb_pop("b_frame_done", 1'b1, {K_DONE, 24'h0});
                check("b_latch_len", 32'(cyc - last_ws_edge_b + 1), 32'(RC));
                have_ws_b = 0;
                after_fd_b = 1;
                fd_count_b++;
            end
            send_prev_b = send_b;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock); #1;
    endtask

    // Reference behaviour of one frame: addresses 0..N-1 read in order, each
    // buffer word presented in the same order, then one frame_done.
    task automatic push_frame();
        for (int i = 0; i < N; i++) begin
            exp_q.push_back({K_READ, 24'(i)});
            exp_q.push_back({K_WORD, mem[i]});
        end
        exp_q.push_back({K_DONE, 24'h0});
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_fd(input string name, input int target);
        int n;
        n = 0;
        while (fd_count < target && n < 2000) begin
            tick();
            n++;
        end
        check(name, 32'(fd_count >= target), 32'd1);
    endtask

    task automatic idle_check(input string name, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            tick();
            check(name, 32'(busy), 32'd0);
        end
    endtask

    task automatic randomize_mem();
        for (int i = 0; i < N; i++) mem[i] = 24'($urandom_range(1, 24'hFFFFFF));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int base;
        mem[0] = 24'hFF0000; mem[1] = 24'h00FF00; mem[2] = 24'h0000FF;

        // reset values
        reset = 1'b1;
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_send", 32'(send), 32'd0);
        check("rst_rd", 32'(pixel_rd), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        check("rst_rgb", 32'(rgb_data), 32'd0);
        check("rst_addr", 32'(pixel_addr), 32'd0);
        tick();
        reset = 1'b0;
        idle_check("idle_after_reset", 5);

        // directed frame with the primary colours
        base = fd_count;
        push_frame();
        pulse_start();
        wait_fd("directed_frame", base + 1);
        idle_check("idle_after_frame", 3);

        // spurious acknowledges while idle
        spur_en = 1'b1;
        idle_check("idle_spurious", 12);
        spur_en = 1'b0;

        // start held high for a whole frame, no repeat
        base = fd_count;
        push_frame();
        start = 1'b1;
        wait_fd("start_held_frame", base + 1);
        start = 1'b0;
        idle_check("idle_after_held", 20);

        // random frames, spurious acks on alternate frames, start mid-frame
        for (int r = 0; r < 5; r++) begin
            randomize_mem();
            spur_en = (r % 2 == 0);
            base = fd_count;
            push_frame();
            pulse_start();
            n = 0;
            while (!send && n < 50) begin tick(); n++; end
            check("send_seen", 32'(send), 32'd1);
            pulse_start();
            wait_fd("random_frame", base + 1);
            spur_en = 1'b0;
            idle_check("idle_after_random", 3);
        end

        // continuous run of three frames, stopped during the last one
        randomize_mem();
        base = fd_count;
        for (int k = 0; k < 3; k++) push_frame();
        continuous = 1'b1;
        pulse_start();
        wait_fd("continuous_run", base + 2);
        continuous = 1'b0;
        wait_fd("continuous_stop", base + 3);
        idle_check("idle_after_continuous", 5);

        // asynchronous reset during the second word
        randomize_mem();
        push_frame();
        pulse_start();
        n = 0;
        while (!(send && pixel_addr == 1) && n < 100) begin tick(); n++; end
        check("reached_pixel1", 32'(send && pixel_addr == 1), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("async_send", 32'(send), 32'd0);
        check("async_busy", 32'(busy), 32'd0);
        check("async_rgb", 32'(rgb_data), 32'd0);
        exp_q.delete();
        tick();
        tick();
        reset = 1'b0;
        idle_check("idle_after_async", 3);
        base = fd_count;
        push_frame();
        pulse_start();
        wait_fd("restart_frame", base + 1);
        idle_check("idle_after_restart", 3);

        // single-pixel strip
        exp_b_q.push_back({K_READ, 24'h0});
        exp_b_q.push_back({K_WORD, 24'h81AB01});
        exp_b_q.push_back({K_DONE, 24'h0});
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        n = 0;
        while (fd_count_b < 1 && n < 200) begin tick(); n++; end
        check("b_frame", 32'(fd_count_b), 32'd1);
        tick();
        tick();
        check("b_idle", 32'(busy_b), 32'd0);

        check("queue_a_empty", 32'(exp_q.size()), 32'd0);
        check("queue_b_empty", 32'(exp_b_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
